// File: rtl/seg7_pkg.sv
// Shared seven-segment constants: active-low glyphs (gfedcba, bit0 = a)
// and active-low one-hot digit enables used by the display blocks.
package seg7_pkg;

    typedef logic [1:0] scan_idx_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] DIG_SEL_0   = 4'b1110;
    localparam logic [3:0] DIG_SEL_1   = 4'b1101;
    localparam logic [3:0] DIG_SEL_2   = 4'b1011;
    localparam logic [3:0] DIG_SEL_3   = 4'b0111;
    localparam logic [3:0] DIG_SEL_OFF = 4'b1111;

    function automatic logic [3:0] dig_sel_of(input scan_idx_t idx);
        logic [3:0] sel;
        sel = DIG_SEL_OFF;
        case (idx)
            2'd0: sel = DIG_SEL_0;
            2'd1: sel = DIG_SEL_1;
            2'd2: sel = DIG_SEL_2;
            2'd3: sel = DIG_SEL_3;
            default: sel = DIG_SEL_OFF;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/seg7_decoder.sv
// Combinational BCD to active-low seven-segment decoder; codes 10-15 go blank.
module seg7_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] i_code,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        case (i_code)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit multiplexed seven-segment scan driver with registered outputs.
// Optional per-digit blinking is built only when SEG7_BLINK_EN is defined.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int SCAN_DIV  = 12500,
    parameter int BLINK_DIV = 64
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] C1_IN,
    input  logic [3:0] C2_IN,
    input  logic [3:0] C3_IN,
    input  logic [3:0] C4_IN,
    input  logic [3:0] BLINK_MASK,
    output logic [6:0] SEG_OUT,
    output logic [3:0] DIG_SEL,
    output logic       SCAN_TICK
);

    localparam int              PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [PW-1:0]   PRESC_TERM = PW'(SCAN_DIV - 1);

    logic [PW-1:0] r_presc;
    scan_idx_t     r_idx;
    logic          r_tick;
    logic [6:0]    r_seg;
    logic [3:0]    r_dig;

    logic          w_term;
    scan_idx_t     w_next_idx;
    logic [3:0]    w_code;
    logic [6:0]    w_glyph;
    logic          w_blank;

    assign w_term     = (r_presc == PRESC_TERM);
    assign w_next_idx = r_idx + 2'd1;

    // Select the digit that becomes active at this advance, so segments and enable switch together.
    always_comb begin
        w_code = C1_IN;
        case (w_next_idx)
            2'd0:    w_code = C1_IN;
            2'd1:    w_code = C2_IN;
            2'd2:    w_code = C3_IN;
            2'd3:    w_code = C4_IN;
            default: w_code = C1_IN;
        endcase
    end

    seg7_decoder u_decoder (
        .i_code (w_code),
        .o_seg  (w_glyph)
    );

`ifdef SEG7_BLINK_EN
    localparam int            BW         = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_TERM = BW'(BLINK_DIV - 1);

    logic [BW-1:0] r_blink_cnt;
    logic          r_blink_phase;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_term) begin
            if (r_blink_cnt == BLINK_TERM) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + BW'(1);
            end
        end
    end

    // Blanking uses the phase in force at the advance and the mask sampled with the code.
    assign w_blank = r_blink_phase & BLINK_MASK[w_next_idx];
`else
    logic w_unused_blink_mask;
    assign w_unused_blink_mask = ^BLINK_MASK;
    assign w_blank             = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_presc <= '0;
            r_idx   <= 2'd3;
            r_tick  <= 1'b0;
            r_seg   <= SEG_BLANK;
            r_dig   <= DIG_SEL_OFF;
        end else begin
            r_tick <= w_term;
            if (w_term) begin
                r_presc <= '0;
                r_idx   <= w_next_idx;
                r_seg   <= w_blank ? SEG_BLANK : w_glyph;
                r_dig   <= dig_sel_of(w_next_idx);
            end else begin
                r_presc <= r_presc + PW'(1);
            end
        end
    end

    assign SEG_OUT   = r_seg;
    assign DIG_SEL   = r_dig;
    assign SCAN_TICK = r_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed scoreboard bench for seg7_scan_driver (SCAN_DIV=4, BLINK_DIV=2).
module tb_seg7_scan_driver;

    localparam int SD = 4;
    localparam int BD = 2;

    logic       CLK;
    logic       RESET;
    logic [3:0] c_in [4];
    logic [3:0] mask;
    logic [6:0] SEG_OUT;
    logic [3:0] DIG_SEL;
    logic       SCAN_TICK;

    int n_assert = 0;
    int n_fail   = 0;

    logic [10:0] q [$];
    logic [10:0] prev;
    logic [1:0]  m_idx;
    int          m_bcnt;
    logic        m_phase;

    seg7_scan_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD)) dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .C1_IN      (c_in[0]),
        .C2_IN      (c_in[1]),
        .C3_IN      (c_in[2]),
        .C4_IN      (c_in[3]),
        .BLINK_MASK (mask),
        .SEG_OUT    (SEG_OUT),
        .DIG_SEL    (DIG_SEL),
        .SCAN_TICK  (SCAN_TICK)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic logic [6:0] glyph(input logic [3:0] code);
        case (code)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [3:0] dig_of(input logic [1:0] idx);
        case (idx)
            2'd0: return 4'b1110;
            2'd1: return 4'b1101;
            2'd2: return 4'b1011;
            default: return 4'b0111;
        endcase
    endfunction

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed tick/seg/dig=%h required %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_idx   = 2'd3;
        m_bcnt  = 0;
        m_phase = 1'b0;
        prev    = {7'h7F, 4'hF};
        q.delete();
    endtask

    // One scan slot: predict the next advance, check the held outputs, then the advance itself.
    task automatic slot(input string tag, input int mid_c3);
        logic [1:0]  nidx;
        logic [6:0]  s;
        logic [10:0] e;
        nidx = m_idx + 2'd1;
        s    = glyph(c_in[nidx]);
`ifdef SEG7_BLINK_EN
        if (m_phase && mask[nidx]) s = 7'h7F;
        if (m_bcnt == BD - 1) begin
            m_bcnt  = 0;
            m_phase = ~m_phase;
        end else begin
            m_bcnt++;
        end
`endif
        q.push_back({s, dig_of(nidx)});
        m_idx = nidx;
        for (int i = 0; i < SD - 1; i++) begin
            @(negedge CLK);
            if (i == 0 && mid_c3 >= 0) c_in[2] = 4'(mid_c3);
            check({tag, "_hold"}, {SCAN_TICK, SEG_OUT, DIG_SEL}, {1'b0, prev});
        end
        @(negedge CLK);
        if (q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s_queue: observed empty scoreboard required one entry", tag);
        end else begin
            e = q.pop_front();
            check({tag, "_adv"}, {SCAN_TICK, SEG_OUT, DIG_SEL}, {1'b1, e});
            prev = e;
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) c_in[i] = 4'd0;
        mask  = 4'b0000;
        RESET = 1'b1;
        model_reset();
        #1;
        check("reset_dark", {SCAN_TICK, SEG_OUT, DIG_SEL}, {1'b0, 7'h7F, 4'hF});
        repeat (2) @(negedge CLK);
        check("reset_hold", {SCAN_TICK, SEG_OUT, DIG_SEL}, {1'b0, 7'h7F, 4'hF});

        c_in[0] = 4'd1; c_in[1] = 4'd2; c_in[2] = 4'd3; c_in[3] = 4'd4;
        RESET = 1'b0;
        for (int i = 0; i < 8; i++) slot("scan", -1);

        c_in[0] = 4'hA;
        for (int i = 0; i < 4; i++) slot("dec_blank", -1);
        c_in[0] = 4'd0;
        for (int i = 0; i < 4; i++) slot("dec_zero", -1);
        c_in[0] = 4'hF; c_in[1] = 4'd6; c_in[3] = 4'd7;
        for (int i = 0; i < 4; i++) slot("dec_mix", -1);
        c_in[0] = 4'd8; c_in[1] = 4'd9; c_in[3] = 4'hC;

        c_in[2] = 4'd5;
        do slot("lat_pre", -1); while (m_idx != 2'd2);
        slot("lat_mid", 9);
        for (int i = 0; i < 4; i++) slot("lat_post", -1);

        @(negedge CLK);
        #2 RESET = 1'b1;
        #1 check("rst_async", {SCAN_TICK, SEG_OUT, DIG_SEL}, {1'b0, 7'h7F, 4'hF});
        @(negedge CLK);
        check("rst_mid_hold", {SCAN_TICK, SEG_OUT, DIG_SEL}, {1'b0, 7'h7F, 4'hF});
        RESET = 1'b0;
        model_reset();
        for (int i = 0; i < 4; i++) slot("rst_restart", -1);

        mask = 4'b0011;
        for (int i = 0; i < 8; i++) slot("blink_0011", -1);
        mask = 4'b1111;
        for (int i = 0; i < 8; i++) slot("blink_1111", -1);
        mask = 4'b0000;
        for (int i = 0; i < 4; i++) slot("blink_off", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
